// File: rtl/pwm_seq.sv
// Table-driven PWM duty sequencer: streams duty vectors from an internal table to a PWM core.
// Optional build macro PWM_SEQ_LOOP_EN enables endless looping via cfg_loop.
module pwm_seq #(
  parameter int DWC = 8,
  parameter int CHN = 1,
  parameter int AW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctl_start,
  input  logic               ctl_stop,
  input  logic [AW-1:0]      cfg_last,
  input  logic [15:0]        cfg_cnt,
  input  logic               cfg_loop,
  input  logic               tbl_we,
  input  logic [AW-1:0]      tbl_adr,
  input  logic [CHN*DWC-1:0] tbl_dat,
  output logic               pwm_ena,
  output logic [CHN*DWC-1:0] str_dat,
  output logic               str_vld,
  input  logic               str_rdy,
  output logic               sts_busy,
  output logic [AW-1:0]      sts_adr,
  output logic               sts_done
);

  localparam int DW    = CHN * DWC;
  localparam int DEPTH = 2 ** AW;

`ifdef PWM_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   adr_reg, adr_next;
  logic [AW-1:0]   cur_adr_reg;
  logic [AW-1:0]   last_reg, last_next;
  logic [15:0]     pass_reg, pass_next;
  logic            loop_reg, loop_next;
  logic            fetch_reg, fetch_next;
  logic            done_reg, done_next;
  logic            rd_en;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // fetch_reg marks the single cycle after a consume in which the next entry is read
  always_comb begin
    state_next = state_reg;
    adr_next   = adr_reg;
    last_next  = last_reg;
    pass_next  = pass_reg;
    loop_next  = loop_reg;
    fetch_next = 1'b0;
    done_next  = 1'b0;
    rd_en      = 1'b0;
    pwm_ena    = 1'b0;
    str_vld    = 1'b0;
    sts_busy   = 1'b0;
    sts_adr    = '0;
    case (state_reg)
      IDLE: begin
        if (ctl_start && !ctl_stop) begin
          state_next = ARM;
          adr_next   = '0;
          pass_next  = cfg_cnt;
          last_next  = cfg_last;
          loop_next  = LOOP_EN && cfg_loop;
        end
      end
      ARM: begin
        sts_busy   = 1'b1;
        rd_en      = 1'b1;
        state_next = ctl_stop ? DRAIN : RUN;
      end
      RUN: begin
        sts_busy = 1'b1;
        pwm_ena  = 1'b1;
        str_vld  = 1'b1;
        sts_adr  = cur_adr_reg;
        rd_en    = fetch_reg;
        if (ctl_stop) begin
          state_next = DRAIN;
        end else if (str_rdy && !fetch_reg) begin
          if (adr_reg != last_reg) begin
            adr_next   = adr_reg + AW'(1);
            fetch_next = 1'b1;
          end else if (loop_reg) begin
            adr_next   = '0;
            fetch_next = 1'b1;
          end else if (pass_reg != 16'd0) begin
            pass_next  = pass_reg - 16'd1;
            adr_next   = '0;
            fetch_next = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        sts_busy = 1'b1;
        pwm_ena  = 1'b1;
        if (str_rdy) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_reg     <= '0;
      cur_adr_reg <= '0;
      last_reg    <= '0;
      pass_reg    <= '0;
      loop_reg    <= 1'b0;
      fetch_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      adr_reg   <= adr_next;
      last_reg  <= last_next;
      pass_reg  <= pass_next;
      loop_reg  <= loop_next;
      fetch_reg <= fetch_next;
      done_reg  <= done_next;
      if (rd_en) cur_adr_reg <= adr_reg;
    end
  end

  // Table is deliberately not reset; the read register only moves on a fetch so the entry holds
  always_ff @(posedge clk) begin
    if (tbl_we) mem[tbl_adr] <= tbl_dat;
    if (rd_en)  rd_data_reg  <= mem[adr_reg];
  end

  generate
    for (genvar gi = 0; gi < CHN; gi++) begin : g_chan
      assign str_dat[gi*DWC +: DWC] = str_vld ? rd_data_reg[gi*DWC +: DWC] : '0;
    end
  endgenerate

  assign sts_done = done_reg;

endmodule

// File: tb/tb_pwm_seq.sv
// Self-checking bench for pwm_seq: directed and randomized sequences against a table/queue model.
module tb_pwm_seq;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ctl_start = 1'b0;
  logic          ctl_stop = 1'b0;
  logic [AW-1:0] cfg_last = '0;
  logic [15:0]   cfg_cnt = '0;
  logic          cfg_loop = 1'b0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_adr = '0;
  logic [DW-1:0] tbl_dat = '0;
  logic          pwm_ena;
  logic [DW-1:0] str_dat;
  logic          str_vld;
  logic          str_rdy = 1'b0;
  logic          sts_busy;
  logic [AW-1:0] sts_adr;
  logic          sts_done;

  logic [DW-1:0] tbl_m [2**AW];
  int            n_assert = 0;
  int            n_fail = 0;
  int            done_cnt = 0;

  pwm_seq #(.DWC(8), .CHN(1), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ctl_start(ctl_start), .ctl_stop(ctl_stop),
    .cfg_last(cfg_last), .cfg_cnt(cfg_cnt), .cfg_loop(cfg_loop),
    .tbl_we(tbl_we), .tbl_adr(tbl_adr), .tbl_dat(tbl_dat),
    .pwm_ena(pwm_ena), .str_dat(str_dat), .str_vld(str_vld), .str_rdy(str_rdy),
    .sts_busy(sts_busy), .sts_adr(sts_adr), .sts_done(sts_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sts_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    tbl_we = 1'b1; tbl_adr = AW'(a); tbl_dat = d;
    tick();
    tbl_we = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".pwm_ena"}, 32'(pwm_ena), 32'd0);
    chk({tag, ".str_vld"}, 32'(str_vld), 32'd0);
    chk({tag, ".str_dat"}, 32'(str_dat), 32'd0);
    chk({tag, ".busy"}, 32'(sts_busy), 32'd0);
    chk({tag, ".adr"}, 32'(sts_adr), 32'd0);
    chk({tag, ".done"}, 32'(sts_done), 32'd0);
  endtask

  // Expected order of presented indices comes from passes x (last+1), or an endless cycle
  task automatic run_case(input string tag, input int last, input int cnt, input bit loop,
                          input int n_rdy, input int stop_at, input bit poke);
    int idx_q[$];
    int d0;
    int shown;
    bit loop_eff;
`ifdef PWM_SEQ_LOOP_EN
    loop_eff = loop;
`else
    loop_eff = 1'b0;
`endif
    if (loop_eff) begin
      for (int p = 0; p <= n_rdy; p++) idx_q.push_back(p % (last + 1));
    end else begin
      for (int c = 0; c <= cnt; c++)
        for (int i = 0; i <= last; i++) idx_q.push_back(i);
    end
    d0 = done_cnt;
    shown = 0;
    cfg_last = AW'(last); cfg_cnt = 16'(cnt); cfg_loop = loop;
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
    cfg_last = AW'($urandom); cfg_cnt = 16'($urandom); cfg_loop = ~loop;
    chk({tag, ".arm_busy"}, 32'(sts_busy), 32'd1);
    chk({tag, ".arm_ena"}, 32'(pwm_ena), 32'd0);
    chk({tag, ".arm_vld"}, 32'(str_vld), 32'd0);
    tick();
    for (int p = 0; p < idx_q.size(); p++) begin
      shown++;
      chk({tag, ".dat"}, 32'(str_dat), 32'(tbl_m[idx_q[p]]));
      chk({tag, ".adr"}, 32'(sts_adr), 32'(idx_q[p]));
      chk({tag, ".vld"}, 32'(str_vld), 32'd1);
      chk({tag, ".ena"}, 32'(pwm_ena), 32'd1);
      if (poke && p == 0) begin
        ctl_start = 1'b1;
        wr(1, 8'd99);
        ctl_start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
      chk({tag, ".hold"}, 32'(str_dat), 32'(tbl_m[idx_q[p]]));
      if (loop_eff && p == n_rdy) begin
        ctl_stop = 1'b1;
        tick();
        ctl_stop = 1'b0;
        break;
      end
      str_rdy = 1'b1;
      ctl_stop = (p == stop_at);
      tick();
      str_rdy = 1'b0;
      ctl_stop = 1'b0;
      if (p == stop_at || p == idx_q.size() - 1) break;
      chk({tag, ".hold_k1"}, 32'(str_dat), 32'(tbl_m[idx_q[p]]));
      chk({tag, ".hold_adr"}, 32'(sts_adr), 32'(idx_q[p]));
      tick();
    end
    chk({tag, ".drain_vld"}, 32'(str_vld), 32'd0);
    chk({tag, ".drain_dat"}, 32'(str_dat), 32'd0);
    chk({tag, ".drain_ena"}, 32'(pwm_ena), 32'd1);
    chk({tag, ".drain_busy"}, 32'(sts_busy), 32'd1);
    chk({tag, ".early_done"}, 32'(done_cnt), 32'(d0));
    ctl_stop = 1'b1;
    tick();
    ctl_stop = 1'b0;
    chk({tag, ".stop_in_drain"}, 32'(pwm_ena), 32'd1);
    repeat ($urandom_range(0, 2)) tick();
    str_rdy = 1'b1;
    tick();
    str_rdy = 1'b0;
    chk({tag, ".done"}, 32'(sts_done), 32'd1);
    chk({tag, ".off_ena"}, 32'(pwm_ena), 32'd0);
    chk({tag, ".off_busy"}, 32'(sts_busy), 32'd0);
    tick();
    chk({tag, ".done_pulse"}, 32'(sts_done), 32'd0);
    chk({tag, ".done_count"}, 32'(done_cnt), 32'(d0 + 1));
    $display("[%s] last=%0d cnt=%0d loop=%0b entries_presented=%0d", tag, last, cnt, loop, shown);
  endtask

  initial begin
    repeat (3) tick();
    chk_idle_zero("reset_hold");
    rst = 1'b0;
    tick();
    chk_idle_zero("reset_rel");

    for (int i = 0; i < 2**AW; i++) wr(i, DW'($urandom));
    wr(0, 8'd10); wr(1, 8'd20); wr(2, 8'd30);

    ctl_start = 1'b1; ctl_stop = 1'b1;
    tick();
    ctl_start = 1'b0; ctl_stop = 1'b0;
    chk("start_stop_busy", 32'(sts_busy), 32'd0);
    tick();
    chk("start_stop_ena", 32'(pwm_ena), 32'd0);

    run_case("single_pass", 2, 0, 1'b0, 0, -1, 1'b0);
    run_case("two_pass", 2, 1, 1'b0, 0, -1, 1'b0);
    run_case("stop_with_rdy", 2, 0, 1'b0, 0, 1, 1'b0);

    cfg_last = 2; cfg_cnt = 0; cfg_loop = 1'b0;
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
    tick();
    str_rdy = 1'b1;
    tick();
    str_rdy = 1'b0;
    tick();
    chk("pre_rst_dat", 32'(str_dat), 32'(tbl_m[1]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("mid_rst");
    $display("[mid_rst] reset applied at entry 1");
    run_case("replay", 2, 0, 1'b0, 0, -1, 1'b0);

    wr(0, 8'd5); wr(1, 8'd7);
    run_case("loop", 1, 0, 1'b1, 10, -1, 1'b0);

    wr(0, 8'd10); wr(1, 8'd20); wr(2, 8'd30);
    run_case("write_live", 2, 1, 1'b0, 0, -1, 1'b1);
    run_case("last_zero", 0, 2, 1'b0, 0, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) wr(i, DW'($urandom));
      run_case("random", $urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               4, (r == 3) ? $urandom_range(0, 2) : -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_seq.md
PWM_SEQ -- requirements
Module: pwm_seq

Interface
REQ-001 SHALL have parameter DWC, default 8, PWM counter width; duty entry width.
REQ-002 SHALL have parameter CHN, default 1, PWM channel count.
REQ-003 SHALL have parameter AW, default 4, table address width; depth 2**AW entries.
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ctl_start  in  1  start pulse; ctl_stop  in  1  stop pulse.
REQ-006 SHALL have cfg_last  in  AW  last table index of sequence; cfg_cnt  in  16  pass count minus one; cfg_loop  in  1  endless loop request.
REQ-007 SHALL have tbl_we  in  1  table write; tbl_adr  in  AW  write address; tbl_dat  in  CHN*DWC  duty vector.
REQ-008 SHALL have pwm_ena  out  1  PWM enable; str_dat  out  CHN*DWC  duty to PWM; str_vld  out  1  data valid; str_rdy  in  1  PWM period end (accept).
REQ-009 SHALL have sts_busy  out  1  sequence active; sts_adr  out  AW  current entry index; sts_done  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement states IDLE, ARM, RUN, DRAIN.
REQ-011 SHALL hold a 2**AW x CHN*DWC table, synchronous write, registered read with 1-cycle latency; read-during-write to the same address returns old data.
REQ-012 IDLE: pwm_ena=0, str_vld=0, str_dat=0; ctl_start=1 and ctl_stop=0 -> ARM, address=0, pass counter=cfg_cnt, cfg_last and cfg_loop latched.
REQ-013 ARM: one cycle fetching entry 0 -> RUN; pwm_ena=1, str_vld=1, str_dat=entry 0 exactly 2 cycles after the start pulse.
REQ-014 RUN: on str_rdy=1 the current entry is consumed; address advances; str_dat SHALL show the next entry 2 cycles after str_rdy and hold it until the next str_rdy.
REQ-015 RUN, str_rdy on entry cfg_last: address wraps to 0 if pass counter>0 (counter decrements) or looping is active; otherwise -> DRAIN.
REQ-016 DRAIN: str_vld=0, str_dat=0, pwm_ena=1; next str_rdy -> IDLE with sts_done=1 for one cycle and pwm_ena=0 the cycle after.
REQ-017 ctl_stop=1 in ARM or RUN -> DRAIN next cycle; ctl_stop in DRAIN or IDLE has no effect.
REQ-018 ctl_start while not IDLE SHALL be ignored; ctl_start and ctl_stop together in IDLE -> remain IDLE.
REQ-019 ctl_stop and str_rdy in the same RUN cycle -> DRAIN; the entry is consumed, no further entries issued.
REQ-020 sts_busy=1 in ARM, RUN, DRAIN; sts_adr = index of entry currently presented on str_dat.
REQ-021 Table writes SHALL be accepted in any state; a write affects a running sequence only at its next fetch of that address.
REQ-022 cfg_last=0 SHALL be legal: a single entry repeated cfg_cnt+1 times.
REQ-023 Pass counter SHALL be 16 bits; cfg_cnt=16'hFFFF gives 65536 passes without overflow.

Reset
REQ-024 rst=1 SHALL force IDLE, pwm_ena=0, str_vld=0, str_dat=0, sts_busy=0, sts_adr=0, sts_done=0, pass counter=0, in any state including mid-sequence.
REQ-025 Table contents SHALL NOT be reset.

Configuration
REQ-026 Macro PWM_SEQ_LOOP_EN defined: cfg_loop=1 latched at start loops the sequence indefinitely (cfg_cnt ignored) until ctl_stop.
REQ-027 PWM_SEQ_LOOP_EN undefined: cfg_loop port SHALL exist but be ignored; sequence always ends after cfg_cnt+1 passes.

Verification
REQ-028 Table {10,20,30}, cfg_last=2, cfg_cnt=0, start at cycle 0 -> str_dat=10, pwm_ena=1 at cycle 2; after three str_rdy sequence 10,20,30 then DRAIN; after fourth str_rdy sts_done pulse, pwm_ena=0 next cycle.
REQ-029 Same table, cfg_cnt=1 -> str_dat sequence 10,20,30,10,20,30 then 0; exactly one sts_done.
REQ-030 RUN on entry 20, assert ctl_stop with str_rdy in same cycle -> str_dat=0, str_vld=0, 30 never presented; done after next str_rdy.
REQ-031 Assert rst during RUN at entry 1 -> next cycle all outputs 0, IDLE; restart without reloading table replays from entry 0 with original values.
REQ-032 With PWM_SEQ_LOOP_EN, cfg_loop=1, cfg_last=1, table {5,7}: 10 str_rdy pulses -> 5,7,5,7,...; no sts_done until ctl_stop; without macro same stimulus -> ends after 5,7.
REQ-033 Write tbl_adr=1 value 99 while entry 0 presented -> next presented entry is 99; ctl_start during RUN -> no change to address or pass count.
